// File: rtl/memory1_pkg.sv
// Shared payload types for the memory1 pipeline stage and its neighbours.
package memory1_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned CSR_ADDR_W  = 14;
  localparam int unsigned TLB_OP_W    = 3;
  localparam int unsigned ECODE_W     = 6;
  localparam int unsigned ESUBCODE_W  = 9;
  localparam int unsigned EXCP_CODE_W = ESUBCODE_W + ECODE_W;
  localparam int unsigned STRB_W      = XLEN / 8;

  typedef enum logic [1:0] {
    BT_BYTE = 2'd0,
    BT_HALF = 2'd1,
    BT_WORD = 2'd2
  } byte_type_e;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [REG_IDX_W-1:0]  rd;
    logic                  is_wr_rd;
    logic                  is_wr_rd_pc_plus4;
    logic [XLEN-1:0]       ex_out;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       rkd_data;
    logic                  is_cac;
    logic                  csr_we;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic                  is_mem;
    logic                  is_store;
    logic                  is_signed;
    byte_type_e            byte_type;
    logic                  is_ertn;
    logic [TLB_OP_W-1:0]   tlb_op;
  } execute_memory1_pass_t;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [REG_IDX_W-1:0]  rd;
    logic                  is_wr_rd;
    logic                  is_wr_rd_pc_plus4;
    logic [XLEN-1:0]       ex_out;
    logic [XLEN-1:0]       pc_plus4;
    logic                  csr_we;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic                  is_mem;
    logic                  is_store;
    logic                  is_signed;
    byte_type_e            byte_type;
    logic [1:0]            addr_lo;
    logic                  is_ertn;
    logic [TLB_OP_W-1:0]   tlb_op;
  } memory1_memory2_pass_t;

  typedef struct packed {
    logic                   valid;
    logic [EXCP_CODE_W-1:0] esubcode_ecode;
    logic [XLEN-1:0]        badv;
  } excp_pass_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
    logic                 data_valid;
    logic [XLEN-1:0]      data;
  } forward_req_t;

endpackage

// File: rtl/memory1_if.sv
// Data-cache request channel between memory1 (master) and the data cache (slave).
interface memory1_if;
  import memory1_pkg::*;

  logic                dc_req_valid;
  logic                dc_req_ready;
  logic [XLEN-1:0]     dc_req_addr;
  logic                dc_req_wr;
  logic [STRB_W-1:0]   dc_req_wstrb;
  logic [XLEN-1:0]     dc_req_wdata;
  logic                dc_req_uncached;
  logic                dc_req_cancel;

  modport master (
    output dc_req_valid, dc_req_addr, dc_req_wr, dc_req_wstrb,
           dc_req_wdata, dc_req_uncached, dc_req_cancel,
    input  dc_req_ready
  );

  modport slave (
    input  dc_req_valid, dc_req_addr, dc_req_wr, dc_req_wstrb,
           dc_req_wdata, dc_req_uncached, dc_req_cancel,
    output dc_req_ready
  );
endinterface

// File: rtl/memory1.sv
// First memory pipeline stage: alignment check, single data-cache request per
// instruction, forwarding source and hand-off to memory2.
module memory1
  import memory1_pkg::*;
#(
  parameter logic [ECODE_W-1:0] ALE_ECODE = 6'h09
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  next_rdy_in,
  output logic                  rdy_in,
  input  execute_memory1_pass_t pass_in,
  input  excp_pass_t            excp_pass_in,
  memory1_if.master             dc,
  output forward_req_t          fwd_req,
  output memory1_memory2_pass_t pass_out,
  output excp_pass_t            excp_pass_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  execute_memory1_pass_t in_q, in_d;
  excp_pass_t            excp_q, excp_d;
  state_e                state_q, state_d;

  logic [1:0] addr_lo;
  logic       misaligned;
  logic       issued;
  logic       need_req;
  logic       m1_flush;
  logic       m1_stall;
  logic       pass_valid;
  logic       req_valid;

  // Natural alignment per access size.
  always_comb begin
    addr_lo    = in_q.ex_out[1:0];
    misaligned = 1'b0;
    case (in_q.byte_type)
      BT_HALF: misaligned = addr_lo[0];
      BT_WORD: misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

  // Stage control, cache request and next-state logic.
  always_comb begin
    state_d    = state_q;
    issued     = (state_q == ST_HELD);
    need_req   = in_q.valid & in_q.is_mem & ~excp_q.valid & ~misaligned & ~flush;
    m1_flush   = flush | ~in_q.valid;
    m1_stall   = ~next_rdy_in | (need_req & ~issued & ~dc.dc_req_ready);
    rdy_in     = m1_flush | ~m1_stall;
    pass_valid = ~m1_flush & ~m1_stall;
    req_valid  = need_req & ~issued;

    in_d   = rdy_in ? pass_in      : in_q;
    excp_d = rdy_in ? excp_pass_in : excp_q;

    dc.dc_req_valid    = req_valid;
    dc.dc_req_addr     = in_q.ex_out;
    dc.dc_req_wr       = in_q.is_store;
    dc.dc_req_uncached = ~in_q.is_cac;
    dc.dc_req_cancel   = flush & issued;
    dc.dc_req_wstrb    = '0;
    dc.dc_req_wdata    = in_q.rkd_data;
    case (in_q.byte_type)
      BT_BYTE: begin
        dc.dc_req_wdata = {4{in_q.rkd_data[7:0]}};
        if (in_q.is_store) dc.dc_req_wstrb = STRB_W'(4'b0001 << addr_lo);
      end
      BT_HALF: begin
        dc.dc_req_wdata = {2{in_q.rkd_data[15:0]}};
        if (in_q.is_store) dc.dc_req_wstrb = STRB_W'(4'b0011 << addr_lo);
      end
      default: begin
        if (in_q.is_store) dc.dc_req_wstrb = 4'b1111;
      end
    endcase

    // HELD means the cache already took this instruction's request.
    case (state_q)
      ST_IDLE: if (req_valid & dc.dc_req_ready & ~next_rdy_in) state_d = ST_HELD;
      ST_HELD: if (next_rdy_in | flush) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs toward memory2 and the forwarding network.
  always_comb begin
    pass_out.valid             = pass_valid;
    pass_out.pc                = in_q.pc;
    pass_out.rd                = in_q.rd;
    pass_out.is_wr_rd          = in_q.is_wr_rd;
    pass_out.is_wr_rd_pc_plus4 = in_q.is_wr_rd_pc_plus4;
    pass_out.ex_out            = in_q.ex_out;
    pass_out.pc_plus4          = in_q.pc_plus4;
    pass_out.csr_we            = in_q.csr_we;
    pass_out.csr_addr          = in_q.csr_addr;
    pass_out.is_mem            = in_q.is_mem;
    pass_out.is_store          = in_q.is_store;
    pass_out.is_signed         = in_q.is_signed;
    pass_out.byte_type         = in_q.byte_type;
    pass_out.addr_lo           = addr_lo;
    pass_out.is_ertn           = in_q.is_ertn;
    pass_out.tlb_op            = in_q.tlb_op;

    // An older exception wins over a newly detected misalignment.
    excp_pass_out = excp_q;
    if (!excp_q.valid && in_q.valid && in_q.is_mem && misaligned) begin
      excp_pass_out.valid          = 1'b1;
      excp_pass_out.esubcode_ecode = {ESUBCODE_W'(0), ALE_ECODE};
      excp_pass_out.badv           = in_q.ex_out;
    end
    excp_pass_out.valid = excp_pass_out.valid & pass_valid;

    fwd_req.valid      = in_q.is_wr_rd & ~m1_flush;
    fwd_req.idx        = in_q.rd;
    fwd_req.data_valid = ~(in_q.is_mem & ~in_q.is_store);
    fwd_req.data       = in_q.is_wr_rd_pc_plus4 ? in_q.pc_plus4 : in_q.ex_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= '0;
      excp_q  <= '0;
      state_q <= ST_IDLE;
    end else begin
      in_q    <= in_d;
      excp_q  <= excp_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_memory1.sv
// Scoreboard bench for memory1: expected hand-offs and cache requests are queued
// when an instruction is sent and checked when the stage produces them.
module tb_memory1;
  import memory1_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  next_rdy_in = 1'b1;
  logic                  rdy_in;
  execute_memory1_pass_t pass_in = '0;
  excp_pass_t            excp_pass_in = '0;
  forward_req_t          fwd_req;
  memory1_memory2_pass_t pass_out;
  excp_pass_t            excp_pass_out;

  memory1_if dc_if ();

  always #5 clk = ~clk;

  memory1 #(.ALE_ECODE(6'h09)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .next_rdy_in   (next_rdy_in),
    .rdy_in        (rdy_in),
    .pass_in       (pass_in),
    .excp_pass_in  (excp_pass_in),
    .dc            (dc_if.master),
    .fwd_req       (fwd_req),
    .pass_out      (pass_out),
    .excp_pass_out (excp_pass_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ev;
    logic [14:0] code;
    logic [31:0] badv;
    logic        fv;
    logic [4:0]  idx;
    logic        dv;
    logic [31:0] fdata;
    logic [4:0]  rd;
    logic [1:0]  alo;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        unc;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  exp_t e;
  req_t r;
  int   n_checks = 0;
  int   n_errs = 0;
  int   cancel_cnt = 0;
  int   req_cycles = 0;
  int   rc;
  int   cc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic execute_memory1_pass_t mk(
    input logic [31:0] pc, input logic [4:0] rd, input logic wr_rd, input logic pc4,
    input logic [31:0] ex_out, input logic [31:0] rkd, input logic mem, input logic st,
    input byte_type_e bt, input logic cac);
    execute_memory1_pass_t p;
    p                   = '0;
    p.valid             = 1'b1;
    p.pc                = pc;
    p.pc_plus4          = pc + 32'd4;
    p.rd                = rd;
    p.is_wr_rd          = wr_rd;
    p.is_wr_rd_pc_plus4 = pc4;
    p.ex_out            = ex_out;
    p.rkd_data          = rkd;
    p.is_mem            = mem;
    p.is_store          = st;
    p.byte_type         = bt;
    p.is_cac            = cac;
    return p;
  endfunction

  task automatic push_pass(input logic [31:0] pc, input logic ev, input logic [14:0] code,
                           input logic [31:0] badv, input logic fv, input logic [4:0] idx,
                           input logic dv, input logic [31:0] fdata, input logic [4:0] rd,
                           input logic [1:0] alo);
    exp_t x;
    x = '{pc, ev, code, badv, fv, idx, dv, fdata, rd, alo};
    exp_q.push_back(x);
  endtask

  task automatic push_req(input logic [31:0] addr, input logic wr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic unc);
    req_t x;
    x = '{addr, wr, wstrb, wdata, unc};
    req_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input execute_memory1_pass_t p, input excp_pass_t ex);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    pass_in      = p;
    excp_pass_in = ex;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = rdy_in;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    pass_in      = '0;
    excp_pass_in = '0;
  endtask

  // Monitor: compare whatever the stage emits against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dc_if.dc_req_cancel) cancel_cnt++;
      if (dc_if.dc_req_valid) req_cycles++;
      if (dc_if.dc_req_valid && dc_if.dc_req_ready) begin
        chk("req_expected", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          chk("req_addr", dc_if.dc_req_addr, r.addr);
          chk("req_wr", 32'(dc_if.dc_req_wr), 32'(r.wr));
          chk("req_wstrb", 32'(dc_if.dc_req_wstrb), 32'(r.wstrb));
          chk("req_wdata", dc_if.dc_req_wdata, r.wdata);
          chk("req_uncached", 32'(dc_if.dc_req_uncached), 32'(r.unc));
        end
      end
      if (pass_out.valid) begin
        chk("pass_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pass_pc", pass_out.pc, e.pc);
          chk("pass_rd", 32'(pass_out.rd), 32'(e.rd));
          chk("pass_addr_lo", 32'(pass_out.addr_lo), 32'(e.alo));
          chk("excp_valid", 32'(excp_pass_out.valid), 32'(e.ev));
          if (e.ev) begin
            chk("excp_code", 32'(excp_pass_out.esubcode_ecode), 32'(e.code));
            chk("excp_badv", excp_pass_out.badv, e.badv);
          end
          chk("fwd_valid", 32'(fwd_req.valid), 32'(e.fv));
          if (e.fv) begin
            chk("fwd_idx", 32'(fwd_req.idx), 32'(e.idx));
            chk("fwd_data_valid", 32'(fwd_req.data_valid), 32'(e.dv));
            chk("fwd_data", fwd_req.data, e.fdata);
          end
        end
      end else begin
        chk("excp_gated", 32'(excp_pass_out.valid), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    excp_pass_t ex;
    dc_if.dc_req_ready = 1'b1;

    // Reset state, with a valid instruction presented at the input.
    pass_in = mk(32'h0, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, BT_WORD, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_rdy_in", 32'(rdy_in), 32'd1);
    chk("rst_req_valid", 32'(dc_if.dc_req_valid), 32'd0);
    chk("rst_cancel", 32'(dc_if.dc_req_cancel), 32'd0);
    chk("rst_pass_valid", 32'(pass_out.valid), 32'd0);
    chk("rst_excp_valid", 32'(excp_pass_out.valid), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_req.valid), 32'd0);
    pass_in = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ld.w 0x1000: one request, no byte enables, load data not yet available.
    rc = req_cycles;
    push_req(32'h1000, 1'b0, 4'b0000, 32'h0, 1'b0);
    push_pass(32'h100, 1'b0, 15'h0, 32'h0, 1'b1, 5'd4, 1'b0, 32'h1000, 5'd4, 2'd0);
    send(mk(32'h100, 5'd4, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, BT_WORD, 1'b1), '0);
    tick(); tick();
    chk("ldw_req_cycles", 32'(req_cycles - rc), 32'd1);

    // st.b 0x1003 uncached: top lane strobe, replicated byte.
    push_req(32'h1003, 1'b1, 4'b1000, 32'hABABABAB, 1'b1);
    push_pass(32'h104, 1'b0, 15'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 2'd3);
    send(mk(32'h104, 5'd0, 1'b0, 1'b0, 32'h1003, 32'h123456AB, 1'b1, 1'b1, BT_BYTE, 1'b0), '0);

    // st.h 0x2002: upper half strobe, replicated halfword.
    push_req(32'h2002, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b0);
    push_pass(32'h108, 1'b0, 15'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 2'd2);
    send(mk(32'h108, 5'd0, 1'b0, 1'b0, 32'h2002, 32'h5555BEEF, 1'b1, 1'b1, BT_HALF, 1'b1), '0);
    tick(); tick();

    // ld.h 0x1001: misaligned, exception raised, no request.
    rc = req_cycles;
    push_pass(32'h10C, 1'b1, 15'h009, 32'h1001, 1'b1, 5'd6, 1'b0, 32'h1001, 5'd6, 2'd1);
    send(mk(32'h10C, 5'd6, 1'b1, 1'b0, 32'h1001, 32'h0, 1'b1, 1'b0, BT_HALF, 1'b1), '0);
    tick(); tick();
    chk("ldh_misalign_no_req", 32'(req_cycles - rc), 32'd0);

    // Prior exception passes through unchanged and suppresses the request.
    ex = '{1'b1, 15'h00B, 32'hDEAD};
    push_pass(32'h110, 1'b1, 15'h00B, 32'hDEAD, 1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 2'd1);
    send(mk(32'h110, 5'd0, 1'b0, 1'b0, 32'h2001, 32'h0, 1'b1, 1'b0, BT_WORD, 1'b1), ex);
    tick(); tick();
    chk("prior_excp_no_req", 32'(req_cycles - rc), 32'd0);

    // st.w accepted while memory2 is stalled: one request, stage holds.
    rc = req_cycles;
    next_rdy_in = 1'b0;
    push_req(32'h3000, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0);
    push_pass(32'h114, 1'b0, 15'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 2'd0);
    send(mk(32'h114, 5'd0, 1'b0, 1'b0, 32'h3000, 32'hCAFEF00D, 1'b1, 1'b1, BT_WORD, 1'b1), '0);
    tick();
    @(negedge clk);
    chk("held_rdy_in", 32'(rdy_in), 32'd0);
    chk("held_no_reissue", 32'(dc_if.dc_req_valid), 32'd0);
    tick(); tick();
    next_rdy_in = 1'b1;
    tick(); tick();
    chk("held_req_cycles", 32'(req_cycles - rc), 32'd1);

    // Flush one cycle after acceptance: cancel pulse, no hand-off.
    cc = cancel_cnt;
    next_rdy_in = 1'b0;
    push_req(32'h3004, 1'b1, 4'b1111, 32'h0BADF00D, 1'b0);
    send(mk(32'h118, 5'd0, 1'b0, 1'b0, 32'h3004, 32'h0BADF00D, 1'b1, 1'b1, BT_WORD, 1'b1), '0);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cancel", 32'(dc_if.dc_req_cancel), 32'd1);
    chk("flush_pass_valid", 32'(pass_out.valid), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_cancel", 32'(dc_if.dc_req_cancel), 32'd0);
    tick();
    next_rdy_in = 1'b1;
    chk("cancel_pulses", 32'(cancel_cnt - cc), 32'd1);

    // add.w rd=5 ex_out 0x7: forwarded with data ready, no request.
    rc = req_cycles;
    push_pass(32'h11C, 1'b0, 15'h0, 32'h0, 1'b1, 5'd5, 1'b1, 32'h7, 5'd5, 2'd3);
    send(mk(32'h11C, 5'd5, 1'b1, 1'b0, 32'h7, 32'h0, 1'b0, 1'b0, BT_WORD, 1'b1), '0);

    // bl-style link write forwards pc+4 rather than ex_out.
    push_pass(32'h200, 1'b0, 15'h0, 32'h0, 1'b1, 5'd1, 1'b1, 32'h204, 5'd1, 2'd1);
    send(mk(32'h200, 5'd1, 1'b1, 1'b1, 32'h999, 32'h0, 1'b0, 1'b0, BT_WORD, 1'b1), '0);
    tick(); tick();
    chk("alu_no_req", 32'(req_cycles - rc), 32'd0);

    // ld.b with the cache not ready: stage stalls until the request is taken.
    dc_if.dc_req_ready = 1'b0;
    push_req(32'h4002, 1'b0, 4'b0000, 32'h0, 1'b0);
    push_pass(32'h204, 1'b0, 15'h0, 32'h0, 1'b1, 5'd7, 1'b0, 32'h4002, 5'd7, 2'd2);
    send(mk(32'h204, 5'd7, 1'b1, 1'b0, 32'h4002, 32'h0, 1'b1, 1'b0, BT_BYTE, 1'b1), '0);
    tick();
    @(negedge clk);
    chk("nrdy_pass_valid", 32'(pass_out.valid), 32'd0);
    chk("nrdy_rdy_in", 32'(rdy_in), 32'd0);
    chk("nrdy_req_valid", 32'(dc_if.dc_req_valid), 32'd1);
    tick();
    dc_if.dc_req_ready = 1'b1;
    tick(); tick();

    // Reset while HELD abandons the request without a cancel.
    next_rdy_in = 1'b0;
    push_req(32'h5000, 1'b1, 4'b1111, 32'h11112222, 1'b0);
    send(mk(32'h208, 5'd0, 1'b0, 1'b0, 32'h5000, 32'h11112222, 1'b1, 1'b1, BT_WORD, 1'b1), '0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_held_cancel", 32'(dc_if.dc_req_cancel), 32'd0);
    chk("rst_held_req_valid", 32'(dc_if.dc_req_valid), 32'd0);
    chk("rst_held_rdy_in", 32'(rdy_in), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_rdy_in = 1'b1;

    // Stage works normally after the mid-request reset.
    push_req(32'h6000, 1'b0, 4'b0000, 32'h0, 1'b0);
    push_pass(32'h20C, 1'b0, 15'h0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h6000, 5'd9, 2'd0);
    send(mk(32'h20C, 5'd9, 1'b1, 1'b0, 32'h6000, 32'h0, 1'b1, 1'b0, BT_WORD, 1'b1), '0);
    repeat (3) tick();

    chk("pass_q_drained", 32'(exp_q.size()), 32'd0);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/memory1.md
MEMORY1 -- requirements
Module: memory1

Interface
REQ-001 Parameter: ALE_ECODE, default 6'h09, exception code reported for a misaligned load/store address.
REQ-002 clk  input  1  stage clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  kill the instruction held in this stage.
REQ-005 next_rdy_in  input  1  memory2 can accept an instruction this cycle.
REQ-006 rdy_in  output  1  this stage can accept pass_in this cycle.
REQ-007 pass_in  input  execute_memory1_pass_t  instruction from execute.
REQ-008 excp_pass_in  input  excp_pass_t  exception state from execute.
REQ-009 dc_req_valid  output  1  data-cache request valid.
REQ-010 dc_req_ready  input  1  data cache accepts the request this cycle.
REQ-011 dc_req_addr  output  32  byte address; equals ex_out.
REQ-012 dc_req_wr  output  1  request is a store.
REQ-013 dc_req_wstrb  output  4  store byte enables; 4'b0000 for loads.
REQ-014 dc_req_wdata  output  32  store data, lane-replicated.
REQ-015 dc_req_uncached  output  1  equals ~is_cac.
REQ-016 dc_req_cancel  output  1  one-cycle pulse: previously accepted request is dead.
REQ-017 fwd_req  output  forward_req_t  forwarding source for decode.
REQ-018 pass_out  output  memory1_memory2_pass_t  instruction to memory2.
REQ-019 excp_pass_out  output  excp_pass_t  exception state to memory2.

Function
REQ-020 Input register (instruction + exception) loads when rdy_in=1; its valid bit clears on reset.
REQ-021 m1_flush = flush | ~valid_r; m1_stall = ~next_rdy_in | (need_req & ~issued & ~dc_req_ready).
REQ-022 rdy_in = m1_flush | ~m1_stall; pass_out.valid = ~m1_flush & ~m1_stall.
REQ-023 Alignment: BYTE never misaligned; HALF misaligned iff addr[0]; WORD misaligned iff addr[1:0]!=0.
REQ-024 need_req = valid_r & is_mem & ~excp_in_r.valid & ~misaligned & ~flush.
REQ-025 Misaligned mem op with no prior exception: excp_pass_out.valid=1, esubcode_ecode={subcode 0, ALE_ECODE}, badv=addr; no cache request.
REQ-026 Prior exception (excp_in_r.valid): passed through unchanged; no cache request.
REQ-027 excp_pass_out.valid is forced 0 whenever pass_out.valid=0.
REQ-028 FSM states IDLE, HELD; reset to IDLE; issued = (state==HELD).
REQ-029 dc_req_valid = need_req & (state==IDLE); each instruction issues exactly one accepted request.
REQ-030 IDLE->HELD when dc_req_valid & dc_req_ready & ~next_rdy_in; HELD->IDLE when next_rdy_in or flush.
REQ-031 Accepted with next_rdy_in=1 in the same cycle: stays IDLE, instruction advances that cycle.
REQ-032 flush while HELD: dc_req_cancel=1 for that cycle, state->IDLE; otherwise dc_req_cancel=0.
REQ-033 wstrb: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<addr[1:0]; WORD 4'b1111.
REQ-034 wdata: BYTE {4{rkd_data[7:0]}}; HALF {2{rkd_data[15:0]}}; WORD rkd_data.
REQ-035 fwd_req.valid = is_wr_rd & ~m1_flush; idx=rd; data_valid = ~(is_mem & ~is_store); data = is_wr_rd_pc_plus4 ? pc_plus4 : ex_out.
REQ-036 pass_out carries pc, rd, is_wr_rd, is_wr_rd_pc_plus4, ex_out, pc_plus4, csr fields, is_mem, is_store, is_signed, byte_type, addr[1:0], is_ertn, tlb_op unchanged.

Reset
REQ-037 During reset: valid_r=0, state=IDLE, dc_req_valid=0, dc_req_cancel=0, pass_out.valid=0, excp_pass_out.valid=0, fwd_req.valid=0, rdy_in=1.
REQ-038 Reset mid-request (HELD): abandons without dc_req_cancel; cache reset is owned elsewhere.

Verification
REQ-039 ld.w addr 0x1000, dc_req_ready=1, next_rdy_in=1 -> dc_req_valid one cycle, wstrb 0, pass_out.valid same cycle, fwd data_valid=0.
REQ-040 st.b addr 0x1003, rkd 0xAB -> wstrb 4'b1000, wdata 0xABABABAB, wr=1.
REQ-041 ld.h addr 0x1001 -> no dc_req_valid, excp_pass_out.valid=1, ecode 0x09, badv 0x1001.
REQ-042 st.w accepted with next_rdy_in=0 for 3 cycles -> single dc_req_valid pulse, state HELD, rdy_in=0, then advance once next_rdy_in=1.
REQ-043 flush one cycle after acceptance in HELD -> dc_req_cancel pulse, pass_out.valid=0, state IDLE.
REQ-044 add.w rd=5 ex_out 0x7 -> fwd_req valid, idx 5, data 0x7, data_valid 1, no cache request.
